// File: rtl/ram_write_arbiter.sv
// ram_write_arbiter
//   Shares the user-side write port of the dual-write on-chip RAM among N
//   requesters with a valid/ready handshake. The RAM drops a user write in any
//   cycle where the host (Avalon) side writes, so the accepted write is held in
//   an output register until a cycle with host_write_n_i high commits it.
//
//   Build option: define RAM_ARB_FIXED_PRIORITY_EN for fixed priority
//   (lowest index wins). The default is round-robin.
//
// Ports
//   clk_i           single clock, shared with the RAM
//   reset_i         synchronous, active-high reset
//   req_valid_i     per-requester write request
//   req_ready_o     per-requester accept (one-hot or zero)
//   req_addr_i      packed addresses, requester i at [i*W +: W]
//   req_data_i      packed data, requester i at [i*B +: B]
//   host_write_n_i  tap of the RAM's Avalon write_n
//   we_o            RAM user write enable
//   wr_addr_o       RAM user write address
//   wr_data_o       RAM user write data
//   grant_id_o      requester whose write sits in the output register
//   busy_o          output register holds a write (same as we_o)
//   stall_count_o   saturating count of cycles a pending write was blocked

module ram_write_arbiter #(
  parameter int N = 4,
  parameter int B = 32,
  parameter int W = 10,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [N-1:0]      req_valid_i,
  output logic [N-1:0]      req_ready_o,
  input  logic [N*W-1:0]    req_addr_i,
  input  logic [N*B-1:0]    req_data_i,
  input  logic              host_write_n_i,
  output logic              we_o,
  output logic [W-1:0]      wr_addr_o,
  output logic [B-1:0]      wr_data_o,
  output logic [IW-1:0]     grant_id_o,
  output logic              busy_o,
  output logic [15:0]       stall_count_o
);

  // state | meaning
  // EMPTY | output register empty, we_o = 0
  // FULL  | output register holds a write, we_o = 1
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [W-1:0]  addr_q, addr_d;
  logic [B-1:0]  data_q, data_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [15:0]   stall_q, stall_d;

  logic          commit;
  logic          free;
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic          transfer;

  // The RAM stores the user write exactly when the host is not writing.
  assign commit = (state_q == ST_FULL) & host_write_n_i;
  assign free   = (state_q == ST_EMPTY) | commit;

`ifdef RAM_ARB_FIXED_PRIORITY_EN
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    // Descending scan so the lowest requesting index is written last and wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (req_valid_i[k]) begin
        win_found = 1'b1;
        win_idx   = IW'(k);
      end
    end
  end
`else
  logic [IW-1:0] last_q, last_d;

  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    // Search order last+1 .. last+N; scanning the offsets downwards lets the
    // nearest requester after the pointer overwrite any farther candidate.
    for (int k = N; k >= 1; k--) begin
      cand = (int'(last_q) + k) % N;
      if (req_valid_i[cand]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (transfer) begin
      last_d = win_idx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_q <= IW'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Ready is masked during reset so nothing is accepted into a register that
  // is about to be cleared.
  assign transfer = free & win_found & ~reset_i;

  always_comb begin
    req_ready_o = '0;
    if (transfer) begin
      req_ready_o[win_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    grant_d = grant_q;
    if (transfer) begin
      state_d = ST_FULL;
      addr_d  = req_addr_i[int'(win_idx)*W +: W];
      data_d  = req_data_i[int'(win_idx)*B +: B];
      grant_d = win_idx;
    end else if (commit) begin
      state_d = ST_EMPTY;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if ((state_q == ST_FULL) && !host_write_n_i && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_EMPTY;
      addr_q  <= '0;
      data_q  <= '0;
      grant_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      stall_q <= stall_d;
    end
  end

  assign we_o          = (state_q == ST_FULL);
  assign busy_o        = we_o;
  assign wr_addr_o     = addr_q;
  assign wr_data_o     = data_q;
  assign grant_id_o    = grant_q;
  assign stall_count_o = stall_q;

endmodule

// File: tb/tb_ram_write_arbiter.sv
module tb_ram_write_arbiter;

  localparam int N  = 4;
  localparam int B  = 32;
  localparam int W  = 10;
  localparam int IW = 2;

  typedef struct packed {
    logic [W-1:0]  a;
    logic [B-1:0]  d;
    logic [IW-1:0] id;
  } wr_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_addr;
  logic [N*B-1:0]  req_data;
  logic            host_write_n;
  logic            we;
  logic [W-1:0]    wr_addr;
  logic [B-1:0]    wr_data;
  logic [IW-1:0]   grant_id;
  logic            busy;
  logic [15:0]     stall_count;

  always #5 clk = ~clk;

  ram_write_arbiter #(.N(N), .B(B), .W(W)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_addr_i    (req_addr),
    .req_data_i    (req_data),
    .host_write_n_i(host_write_n),
    .we_o          (we),
    .wr_addr_o     (wr_addr),
    .wr_data_o     (wr_data),
    .grant_id_o    (grant_id),
    .busy_o        (busy),
    .stall_count_o (stall_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Requester-side view: what each requester is currently offering.
  logic          r_valid [N];
  logic [W-1:0]  r_addr  [N];
  logic [B-1:0]  r_data  [N];

  // Reference model (spec-level): slot occupancy, last-accepted pointer,
  // stall counter, plus a queue of accepted writes awaiting commit.
  bit            m_known = 1'b0;
  bit            m_full  = 1'b0;
  int            m_last  = N - 1;
  int            m_stall = 0;
  wr_t           sb_q[$];
  int            gnt_log[$];

  // Per-cycle expectations handed from stimulus to monitor.
  logic [N-1:0]  exp_ready = '0;
  bit            exp_we    = 1'b0;
  int            exp_stall = 0;
  bit            chk_state = 1'b0;
  bit            cur_rst   = 1'b1;
  bit            cur_hn    = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus plus the reference-model step for it.
  task automatic step(input bit rst, input bit hn);
    bit fnd;
    bit fr;
    int w;
    wr_t e;
    @(negedge clk);
    chk_state = m_known;
    exp_we    = m_full;
    exp_stall = m_stall;
    reset        = rst;
    host_write_n = hn;
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = r_valid[i];
      req_addr[i*W +: W]   = r_addr[i];
      req_data[i*B +: B]   = r_data[i];
    end
    cur_rst = rst;
    cur_hn  = hn;
    fr  = !m_full || hn;
    fnd = 1'b0;
    w   = 0;
`ifdef RAM_ARB_FIXED_PRIORITY_EN
    for (int k = 0; k < N; k++)
      if (!fnd && r_valid[k]) begin fnd = 1'b1; w = k; end
`else
    for (int k = 1; k <= N; k++)
      if (!fnd && r_valid[(m_last + k) % N]) begin fnd = 1'b1; w = (m_last + k) % N; end
`endif
    exp_ready = '0;
    if (fr && fnd && !rst) exp_ready[w] = 1'b1;
    if (rst) begin
      m_known = 1'b1;
      m_full  = 1'b0;
      m_last  = N - 1;
      m_stall = 0;
      sb_q.delete();
    end else begin
      if (m_full && !hn && m_stall < 65535) m_stall++;
      if (exp_ready != '0) begin
        e.a  = r_addr[w];
        e.d  = r_data[w];
        e.id = IW'(w);
        sb_q.push_back(e);
        m_full    = 1'b1;
        m_last    = w;
        r_valid[w] = 1'b0;
      end else if (m_full && hn) begin
        m_full = 1'b0;
      end
    end
  endtask

  // Monitor: samples just before each rising edge.
  always @(negedge clk) begin
    wr_t e;
    #4;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    if (chk_state) begin
      chk("we", 64'(we), 64'(exp_we));
      chk("busy", 64'(busy), 64'(exp_we));
      chk("stall_count", 64'(stall_count), 64'(exp_stall));
      if (we && cur_hn && !cur_rst) begin
        if (sb_q.size() == 0) begin
          chk("commit_expected", 64'(1), 64'(0));
        end else begin
          e = sb_q.pop_front();
          chk("wr_addr", 64'(wr_addr), 64'(e.a));
          chk("wr_data", 64'(wr_data), 64'(e.d));
          chk("grant_id", 64'(grant_id), 64'(e.id));
          gnt_log.push_back(int'(grant_id));
        end
      end
    end
  end

  task automatic clear_req();
    for (int i = 0; i < N; i++) begin
      r_valid[i] = 1'b0;
      r_addr[i]  = '0;
      r_data[i]  = '0;
    end
  endtask

  initial begin
    reset        = 1'b1;
    host_write_n = 1'b1;
    req_valid    = '0;
    req_addr     = '0;
    req_data     = '0;
    clear_req();
    step(1, 1);
    step(1, 1);

    // Single request from requester 2.
    r_valid[2] = 1'b1; r_addr[2] = 10'h005; r_data[2] = 32'hDEADBEEF;
    step(0, 1);
    #4 chk("single_ready", 64'(req_ready), 64'h4);
    step(0, 1);
    #4;
    chk("single_we", 64'(we), 64'(1));
    chk("single_addr", 64'(wr_addr), 64'h005);
    chk("single_data", 64'(wr_data), 64'hDEADBEEF);
    chk("single_id", 64'(grant_id), 64'(2));
    step(0, 1);
    #4 chk("single_we_drop", 64'(we), 64'(0));

    // Round-robin with all requesters held valid.
    step(1, 1);
    gnt_log.delete();
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) begin
        r_valid[i] = 1'b1;
        r_addr[i]  = W'($urandom);
        r_data[i]  = $urandom;
      end
      step(0, 1);
      if (c > 0) begin
        #4 chk("rr_we_every_cycle", 64'(we), 64'(1));
      end
    end
    clear_req();
    step(0, 1);
    step(0, 1);
    chk("rr_count", 64'(gnt_log.size()), 64'(8));
    for (int c = 0; c < 8 && c < gnt_log.size(); c++) begin
`ifdef RAM_ARB_FIXED_PRIORITY_EN
      chk("rr_order", 64'(gnt_log[c]), 64'(0));
`else
      chk("rr_order", 64'(gnt_log[c]), 64'(c % 4));
`endif
    end

    // Host collision: 3-cycle host write over a pending write to 0x010.
    step(1, 1);
    r_valid[1] = 1'b1; r_addr[1] = 10'h010; r_data[1] = 32'h1234_5678;
    step(0, 1);
    r_valid[3] = 1'b1; r_addr[3] = 10'h011; r_data[3] = 32'h0BAD_F00D;
    for (int c = 0; c < 3; c++) begin
      step(0, 0);
      #4;
      chk("coll_hold_we", 64'(we), 64'(1));
      chk("coll_ready_zero", 64'(req_ready), 64'(0));
    end
    step(0, 1);
    #4;
    chk("coll_stall3", 64'(stall_count), 64'(3));
    chk("coll_commit_addr", 64'(wr_addr), 64'h010);
    step(0, 1);
    step(0, 1);

    // Back-to-back with a one-cycle host write.
    step(1, 1);
    r_valid[0] = 1'b1; r_addr[0] = 10'h100; r_data[0] = 32'hAAAA_0000;
    r_valid[1] = 1'b1; r_addr[1] = 10'h101; r_data[1] = 32'hBBBB_1111;
    step(0, 1);
    step(0, 0);
    #4 chk("b2b_blocked", 64'(req_ready), 64'(0));
    step(0, 1);
    #4 chk("b2b_r1_at_commit", 64'(req_ready), 64'h2);
    step(0, 1);
    step(0, 1);

    // Reset while FULL and the host is writing.
    r_valid[2] = 1'b1; r_addr[2] = 10'h03F; r_data[2] = 32'hCAFE_0001;
    step(0, 1);
    step(0, 0);
    step(1, 0);
    step(0, 1);
    #4;
    chk("rst_hold_we", 64'(we), 64'(0));
    chk("rst_hold_stall", 64'(stall_count), 64'(0));

    // Randomized traffic with host writes and occasional resets.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!r_valid[i] && $urandom_range(2) == 0) begin
          r_valid[i] = 1'b1;
          r_addr[i]  = W'($urandom);
          r_data[i]  = $urandom;
        end
      end
      step(($urandom_range(199) == 0), ($urandom_range(3) != 0));
    end
    clear_req();
    step(0, 1);
    step(0, 1);

    // Saturation of the stall counter.
    step(1, 1);
    r_valid[0] = 1'b1; r_addr[0] = 10'h2AA; r_data[0] = 32'h5555_AAAA;
    step(0, 1);
    for (int c = 0; c < 70000; c++) step(0, 0);
    #4 chk("stall_saturated", 64'(stall_count), 64'hFFFF);
    step(0, 1);
    step(0, 1);
    step(0, 1);
    chk("sb_drained", 64'(sb_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
